// File: rtl/register_5bits_pkg.sv
// Shared constants for the register_5bits datapath holding register.
// Sized so the default instance is the 5-bit control-unit register.
package register_5bits_pkg;

    localparam int DEFAULT_WIDTH = 5;

    localparam logic DEFAULT_RESET_BIT = 1'b0;

endpackage

// File: rtl/register_bit_cell.sv
// Single storage bit: async active-low reset, synchronous clear, load enable.
// Clear shares the reset value so a cleared cell matches a freshly reset one.
module register_bit_cell #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    input  logic load,
    input  logic clear,
    output logic q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_VALUE;
        end else if (clear) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_5bits.sv
// Loadable holding register built from per-bit cells.
// Output is purely registered; register_in never bypasses to out.
module register_5bits
    import register_5bits_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] register_in,
    input  logic             load,
    input  logic             clear,
    output logic [WIDTH-1:0] out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        register_bit_cell #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .d       (register_in[i]),
            .load    (load),
            .clear   (clear),
            .q       (out[i])
        );
    end

endmodule

// File: tb/tb_register_5bits.sv
// Table-driven bench for register_5bits with an expected-value queue.
module tb_register_5bits;

    logic       clock;
    logic       reset_n;
    logic [4:0] register_in;
    logic       load;
    logic       clear;
    logic [4:0] out;

    int vectors;
    int miscompares;

    logic [4:0] exp_q[$];
    string      name_q[$];

    typedef struct {
        logic       clr;
        logic       ld;
        logic [4:0] din;
        logic [4:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[14];

    register_5bits #(
        .WIDTH       (5),
        .RESET_VALUE (5'd0)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .register_in (register_in),
        .load        (load),
        .clear       (clear),
        .out         (out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic expect_val(input logic [4:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic compare_out();
        logic [4:0] e;
        string      nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        vectors++;
        if (out !== e) begin
            miscompares++;
            $display("FAIL %s: out=%0d expected=%0d", nm, out, e);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [4:0] d);
        clear       = c;
        load        = l;
        register_in = d;
        if ($isunknown({c, l})) begin
            miscompares++;
            $display("FAIL xstim: load=%b clear=%b must be known", l, c);
        end
    endtask

    task automatic step(input logic c, input logic l, input logic [4:0] d,
                        input logic [4:0] e, input string nm);
        @(negedge clock);
        drive(c, l, d);
        expect_val(e, nm);
        @(posedge clock);
        #1;
        compare_out();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        vecs[0]  = '{1'b0, 1'b1, 5'd3,      5'd3,  "load3"};
        vecs[1]  = '{1'b0, 1'b0, 5'd10,     5'd3,  "hold1"};
        vecs[2]  = '{1'b0, 1'b0, 5'd10,     5'd3,  "hold2"};
        vecs[3]  = '{1'b0, 1'b0, 5'd10,     5'd3,  "hold3"};
        vecs[4]  = '{1'b1, 1'b1, 5'(33),    5'd0,  "clr_ld"};
        vecs[5]  = '{1'b1, 1'b0, 5'(50),    5'd0,  "clr_only"};
        vecs[6]  = '{1'b0, 1'b1, 5'd31,     5'd31, "b2b31"};
        vecs[7]  = '{1'b0, 1'b1, 5'd0,      5'd0,  "b2b0"};
        vecs[8]  = '{1'b0, 1'b1, 5'd21,     5'd21, "b2b21"};
        vecs[9]  = '{1'b0, 1'b1, 5'd10,     5'd10, "b2b10"};
        vecs[10] = '{1'b1, 1'b0, 5'd10,     5'd0,  "clr1"};
        vecs[11] = '{1'b0, 1'b1, 5'd31,     5'd31, "reload31"};
        vecs[12] = '{1'b0, 1'b0, 5'd5,      5'd31, "hold31"};
        vecs[13] = '{1'b0, 1'b1, 5'(33),    5'd1,  "trunc33"};

        reset_n = 1'b0;
        drive(1'b0, 1'b1, 5'd3);
        #1;
        expect_val(5'd0, "reset_init");
        compare_out();

        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            expect_val(5'd0, "reset_hold");
            compare_out();
        end

        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 5'd3, 5'd3, "first_load");

        #2;
        reset_n = 1'b0;
        #1;
        expect_val(5'd0, "async_reset");
        compare_out();

        @(negedge clock);
        drive(1'b0, 1'b1, 5'd7);
        reset_n = 1'b1;
        #1;
        expect_val(5'd0, "release_pre");
        compare_out();
        @(posedge clock);
        #1;
        expect_val(5'd7, "release_edge");
        compare_out();

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].clr, vecs[i].ld, vecs[i].din, vecs[i].exp, vecs[i].name);
        end

        @(negedge clock);
        drive(1'b1, 1'b1, 5'd9);
        reset_n = 1'b0;
        #1;
        expect_val(5'd0, "reset_vs_clr");
        compare_out();
        @(posedge clock);
        #1;
        expect_val(5'd0, "reset_vs_clr_edge");
        compare_out();

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
